// File: rtl/tile_sequencer_if.sv
// tile_sequencer_if: control/status bundle between the decoder, buffers, array, accumulator and tile_sequencer.
// master: start, k_tiles, w_avail, if_avail, acc_done out; read strobes, switch, first, last, busy, done, tile_idx in.
// slave: the mirror image, used by tile_sequencer.
interface tile_sequencer_if #(
  parameter int KT_W = 5
);
  logic start;
  logic [KT_W-1:0] k_tiles;
  logic w_avail;
  logic if_avail;
  logic acc_done;
  logic w_buffer_read;
  logic if_buffer_read;
  logic switch;
  logic first;
  logic last;
  logic busy;
  logic done;
  logic [KT_W-1:0] tile_idx;
  modport master (
    output start, k_tiles, w_avail, if_avail, acc_done,
    input w_buffer_read, if_buffer_read, switch, first, last, busy, done, tile_idx
  );
  modport slave (
    input start, k_tiles, w_avail, if_avail, acc_done,
    output w_buffer_read, if_buffer_read, switch, first, last, busy, done, tile_idx
  );
endinterface

// File: rtl/tile_sequencer.sv
// tile_sequencer: FSM that loads weight tiles, streams input tiles, drains the systolic array and waits for the accumulator.
// Ports: clk, rst (sync, active-low), bus (tile_sequencer_if.slave: start/k_tiles/w_avail/if_avail/acc_done in;
// w_buffer_read/if_buffer_read/switch/first/last/busy/done/tile_idx out).
// Option: define TILE_PRELOAD_EN to preload the next tile's weights while the current tile streams.
module tile_sequencer #(
  parameter int SYS_ROWS = 4,
  parameter int SYS_COLS = 4,
  parameter int A_ROWS = 8,
  parameter int KT_W = 5
) (
  input logic clk,
  input logic rst,
  tile_sequencer_if.slave bus
);
  localparam int DRAIN_N = SYS_ROWS + SYS_COLS - 1;
  localparam int MAXC = A_ROWS > DRAIN_N ? A_ROWS : DRAIN_N;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] R_LAST = CW'(SYS_ROWS - 1);
  localparam logic [CW-1:0] A_LAST = CW'(A_ROWS - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DRAIN_N - 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, SWAP, STREAM, DRAIN, WAIT_ACC} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [KT_W-1:0] kt, tile_idx;
  logic done_r, last_t, w_rd, if_rd, pre_rd;
`ifdef TILE_PRELOAD_EN
  localparam int SW = $clog2(SYS_ROWS + 1);
  localparam logic [SW-1:0] SH_FULL = SW'(SYS_ROWS);
  logic [SW-1:0] sh, sh_n;
`endif
  always_comb begin
    last_t = tile_idx == kt - KT_W'(1);
    w_rd = state == LOAD_W && bus.w_avail;
    if_rd = state == STREAM && bus.if_avail;
    pre_rd = 1'b0;
`ifdef TILE_PRELOAD_EN
    pre_rd = state == STREAM && !last_t && sh != SH_FULL && bus.w_avail;
    sh_n = sh + SW'(pre_rd);
`endif
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.start) begin
        state_n = LOAD_W;
        cnt_n = '0;
      end
      LOAD_W: if (w_rd) begin
        cnt_n = cnt == R_LAST ? '0 : cnt + CW'(1);
        state_n = cnt == R_LAST ? SWAP : LOAD_W;
      end
      SWAP: state_n = STREAM;
      STREAM: if (if_rd) begin
        cnt_n = cnt == A_LAST ? '0 : cnt + CW'(1);
        state_n = cnt != A_LAST ? STREAM : last_t ? DRAIN : LOAD_W;
`ifdef TILE_PRELOAD_EN
        // a full shadow load skips LOAD_W; a partial one resumes LOAD_W where it stopped
        if (cnt == A_LAST && !last_t) begin
          state_n = sh_n == SH_FULL ? SWAP : LOAD_W;
          cnt_n = sh_n == SH_FULL ? '0 : CW'(sh_n);
        end
`endif
      end
      DRAIN: begin
        cnt_n = cnt == D_LAST ? '0 : cnt + CW'(1);
        state_n = cnt == D_LAST ? WAIT_ACC : DRAIN;
      end
      WAIT_ACC: state_n = bus.acc_done ? IDLE : WAIT_ACC;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      kt <= '0;
      tile_idx <= '0;
      done_r <= 1'b0;
`ifdef TILE_PRELOAD_EN
      sh <= '0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      done_r <= state == WAIT_ACC && bus.acc_done;
      if (state == IDLE && bus.start) begin
        kt <= bus.k_tiles == '0 ? KT_W'(1) : bus.k_tiles;
        tile_idx <= '0;
      end else if (state == STREAM && state_n != STREAM && !last_t) begin
        tile_idx <= tile_idx + KT_W'(1);
      end
`ifdef TILE_PRELOAD_EN
      sh <= state == STREAM && state_n == STREAM ? sh_n : '0;
`endif
    end
  end
  assign bus.w_buffer_read = w_rd | pre_rd;
  assign bus.if_buffer_read = if_rd;
  assign bus.switch = state == SWAP;
  assign bus.first = state == STREAM && tile_idx == '0;
  assign bus.last = state == STREAM && last_t;
  assign bus.busy = state != IDLE;
  assign bus.done = done_r;
  assign bus.tile_idx = tile_idx;
endmodule

// File: doc/tile_sequencer.md
# tile_sequencer

- Parametrised control sequencer for the systolic matrix-multiply datapath.
- Replaces the externally driven `w_buffer_read` / `if_buffer_read` / `switch` / `first` / `last` strobes with an internal state machine.
- Streams `k_tiles` weight/input tile pairs through the array, then drains it and waits for the accumulator.
- Sits between the instruction decoder (start/done handshake) and the buffers, systolic array and accumulator.

## Interface

Parameters:

- `SYS_ROWS`, default 4: systolic array rows; equals weight rows loaded per tile.
- `SYS_COLS`, default 4: systolic array columns; sets drain length.
- `A_ROWS`, default 8: input-feature rows streamed per tile.
- `KT_W`, default 5: width of the tile-count field (max 2^KT_W−1 tiles).

Ports:

- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: begin an operation; sampled only in IDLE.
- `k_tiles` in KT_W: tile count; latched on accepted `start`; 0 is treated as 1.
- `w_avail` in 1: weight buffer holds a row to read.
- `if_avail` in 1: input buffer holds a row to read.
- `acc_done` in 1: accumulator finished writing results.
- `w_buffer_read` out 1: weight row read strobe.
- `if_buffer_read` out 1: input row read strobe.
- `switch` out 1: one-cycle weight-register swap pulse to the array.
- `first` out 1: current streamed tile is tile 0.
- `last` out 1: current streamed tile is the final tile.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle completion pulse.
- `tile_idx` out KT_W: index of the tile being streamed.

## Operation

- States: IDLE, LOAD_W, SWAP, STREAM, DRAIN, WAIT_ACC.
- IDLE: `start`=1 latches `max(k_tiles,1)`, clears `tile_idx` and counters, then moves to LOAD_W.
- LOAD_W:
  - `w_buffer_read = w_avail`; the row counter increments only on a read.
  - When the counter reaches SYS_ROWS, go to SWAP.
  - `w_avail`=0 stalls without limit.
- SWAP: `switch`=1 for exactly one cycle, then go to STREAM.
- STREAM:
  - `if_buffer_read = if_avail`; the stream counter increments on each read.
  - `first` = (`tile_idx`==0); `last` = (`tile_idx`==latched count−1). Both are held for the whole STREAM state.
  - After A_ROWS reads: if not the last tile, increment `tile_idx` and go to LOAD_W; otherwise go to DRAIN.
- DRAIN: fixed SYS_ROWS+SYS_COLS−1 cycles, then go to WAIT_ACC.
- WAIT_ACC: when `acc_done`=1, assert `done` for one cycle and return to IDLE.
- All outputs are decoded from registered state and counters (Moore). No output depends combinationally on `start` or `acc_done`.
- `w_avail`/`if_avail` reach the read strobes combinationally; this is the only combinational path.
- Boundary rules:
  - `start` while busy is ignored.
  - `acc_done` outside WAIT_ACC is ignored.
  - `k_tiles`=1 gives `first`=`last`=1 on the single tile.
  - `tile_idx` never wraps. The maximum count is 2^KT_W−1 and the last index is count−1.

## Timing

- Reset (`rst`=0 at a clock edge): state IDLE, all counters 0, all outputs 0, `tile_idx`=0. A reset mid-operation abandons the operation with no `done`.
- `start` sampled at edge N: LOAD_W is active in cycle N+1.
- Unstalled single-tile latency from `start` edge to DRAIN entry: SYS_ROWS+1+A_ROWS cycles. DRAIN adds SYS_ROWS+SYS_COLS−1 cycles.
- `done` is high in the cycle after the edge that samples `acc_done`=1. `busy` falls in the same cycle.
- Each stall cycle delays all later events by exactly one cycle.

## Configuration

- `TILE_PRELOAD_EN` defined:
  - During STREAM of a non-last tile, `w_buffer_read` is also asserted (gated by `w_avail`) to preload up to SYS_ROWS rows of the next tile into a shadow counter.
  - At the end of STREAM: if the shadow count is SYS_ROWS, go directly to SWAP. Otherwise go to LOAD_W, which resumes from the shadow count.
  - No preload occurs during the last tile.
- `TILE_PRELOAD_EN` undefined: strictly serial load then stream. `w_buffer_read` is never asserted outside LOAD_W.

## Test plan

All scenarios use SYS_ROWS=4, SYS_COLS=4, A_ROWS=8.

- Single tile, no stalls: `k_tiles`=1, avail always 1, `acc_done` 3 cycles after DRAIN ends.
  - `w_buffer_read` for 4 cycles, `switch` for 1, `if_buffer_read` for 8 with `first`=`last`=1.
  - 7 drain cycles, then one `done` pulse.
- Three tiles, preload off:
  - `tile_idx` steps 0→1→2.
  - `first` only on tile 0; `last` only on tile 2.
  - Exactly 12 weight reads, 24 input reads and 3 `switch` pulses.
- Stalls: `w_avail`=0 for 5 cycles mid-LOAD_W, `if_avail` toggling every cycle → read counts are unchanged (4 and 8); total latency grows by exactly the number of stall cycles.
- `k_tiles`=0 → behaves identically to `k_tiles`=1; `start` pulsed during STREAM → ignored.
- `rst`=0 during STREAM of tile 1 → the next cycle is IDLE with all outputs 0; no `done`; a new `start` runs normally.
- `TILE_PRELOAD_EN` with `k_tiles`=2, no stalls: STREAM of tile 0 goes directly to SWAP. Total cycles from `start` to DRAIN = 4+1+8+1+8 = 22.
